// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - M-op codes, FSM states and operand signedness helpers
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } func3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // MUL is run unsigned: its low word matches the signed product.
  function automatic logic a_signed(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide registers and result fixup
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic            fast,
  input  logic            is_div,
  input  logic            is_rem,
  input  logic            hi_sel,
  input  logic            sign_a,
  input  logic            sign_b,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  input  logic [XLEN-1:0] fast_val,
  output logic [XLEN-1:0] result
);

  // hi: product high half / remainder; lo: multiplier+product low / dividend+quotient
  logic [XLEN-1:0]   hi, lo, bq;
  logic [XLEN:0]     sum, mul_t, shifted;
  logic [XLEN-1:0]   sub;
  logic              ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fixed;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, bq};
    mul_t   = lo[0] ? sum : {1'b0, hi};
    shifted = {hi, lo[XLEN-1]};
    ge      = shifted >= {1'b0, bq};
    sub     = shifted[XLEN-1:0] - bq;
    prod    = {hi, lo};
    prod_s  = (sign_a ^ sign_b) ? -prod : prod;
    quo_s   = (sign_a ^ sign_b) ? -lo : lo;
    rem_s   = sign_a ? -hi : hi;
    if (is_div)
      fixed = is_rem ? rem_s : quo_s;
    else
      fixed = hi_sel ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      bq     <= '0;
      result <= '0;
    end else begin
      if (load) begin
        hi <= '0;
        lo <= mag_a;
        bq <= mag_b;
      end else if (step) begin
        if (is_div) begin
          hi <= ge ? sub : shifted[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ge};
        end else begin
          hi <= mul_t[XLEN:1];
          lo <= {mul_t[0], lo[XLEN-1:1]};
        end
      end
      if (fast)
        result <= fast_val;
      else if (fix)
        result <= fixed;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M sequencer: FSM, iteration counter, fast paths
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_e          state, state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            sign_a_q, sign_b_q;
  logic            load, step, fix, fast;
  logic            neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;

  always_comb begin
    neg_a    = a_signed(func3) & op_a[XLEN-1];
    neg_b    = b_signed(func3) & op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    div0     = func3[2] && (op_b == '0);
    ovf      = ((func3 == F_DIV) || (func3 == F_REM)) && (op_a == MIN_INT) && (op_b == ALL_ONES);
    // func3[1] distinguishes REM/REMU from DIV/DIVU
    fast_val = div0 ? (func3[1] ? op_a : ALL_ONES) : (func3[1] ? '0 : MIN_INT);
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    fast    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load = 1'b1;
        if (div0 || ovf) begin
          fast    = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_n = S_FIX;
      end
      S_FIX: begin
        fix     = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state_n == S_DONE);
      if (load) begin
        cnt      <= '0;
        f3_q     <= func3;
        sign_a_q <= neg_a;
        sign_b_q <= neg_b;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stall = start & ~done;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .fast     (fast),
    .is_div   (f3_q[2]),
    .is_rem   (f3_q[1]),
    .hi_sel   (f3_q != F_MUL),
    .sign_a   (sign_a_q),
    .sign_b   (sign_b_q),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .fast_val (fast_val),
    .result   (result)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;          return p[31:0];  end
      3'd1: begin p = sa * sb;          return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;          return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("spurious_done", {63'b0, done}, 64'd0);
      else check($sformatf("result_f%0d", func3), {32'b0, result}, {32'b0, exp_q.pop_front()});
    end
  end

  // poke>0 flips op_a and func3 that many samples into the op
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int poke);
    int lat, stalls, exp_lat;
    logic got;
    exp_lat = ref_latency(f, a, b);
    @(posedge clk); #1;
    func3 = f; op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back(ref_model(f, a, b));
    lat = 0; stalls = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (stall) stalls++;
      if (poke > 0 && lat == poke) begin
        op_a = ~op_a;
        func3 = func3 ^ 3'b011;
      end
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    check($sformatf("done_seen_f%0d", f), {63'b0, got}, 64'd1);
    check($sformatf("latency_f%0d", f), 64'(lat - 1), 64'(exp_lat));
    check($sformatf("stall_cycles_f%0d", f), 64'(stalls), 64'(exp_lat));
  endtask

  initial begin
    int t1, t2, n_done;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_result", {32'b0, result}, 64'd0);
    check("reset_stall", {63'b0, stall}, 64'd0);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);
    run_op(3'd0, 32'h1234_5678, 32'h0000_9ABC, 8);

    @(posedge clk); #1;
    func3 = 3'd0; op_a = 32'hDEAD_BEEF; op_b = 32'd3; start = 1'b1;
    repeat (11) @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    @(posedge clk); #1;
    func3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
    exp_q.push_back(ref_model(3'd0, 32'd7, 32'hFFFF_FFFD));
    t1 = -1000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin t1 = cyc; break; end
    end
    op_a = 32'd9; op_b = 32'd11;
    exp_q.push_back(ref_model(3'd0, 32'd9, 32'd11));
    t2 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin t2 = cyc; break; end
    end
    start = 1'b0;
    check("b2b_gap", 64'(t2 - t1), 64'd35);

    for (int n = 0; n < 10; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (n == 3) ? 32'd0 : $urandom;
      if (n == 5) rb = rb >> 20;
      run_op(rf, ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
